// File: rtl/job_control_if.sv
// PSL job-control bundle: host job command/status signals plus the accelerator core handshake.
// The slave modport is the job_control engine's view; master is everything around it.
interface job_control_if #(
    parameter int CNT_W = 32
);
    logic             ha_jval;
    logic [0:7]       ha_jcom;
    logic             ha_jcompar;
    logic [0:63]      ha_jea;
    logic             ha_jeapar;
    logic             core_done;
    logic [0:63]      core_error;
    logic             ah_jrunning;
    logic             ah_jdone;
    logic             ah_jcack;
    logic [0:63]      ah_jerror;
    logic             core_start;
    logic             core_reset;
    logic [0:63]      job_ea;
    logic [CNT_W-1:0] run_cycles;

    modport master (
        output ha_jval, ha_jcom, ha_jcompar, ha_jea, ha_jeapar, core_done, core_error,
        input  ah_jrunning, ah_jdone, ah_jcack, ah_jerror, core_start, core_reset, job_ea, run_cycles
    );

    modport slave (
        input  ha_jval, ha_jcom, ha_jcompar, ha_jea, ha_jeapar, core_done, core_error,
        output ah_jrunning, ah_jdone, ah_jcack, ah_jerror, core_start, core_reset, job_ea, run_cycles
    );
endinterface

// File: rtl/job_control.sv
// PSL job-control engine: decodes job commands, sequences reset/start/done towards the host
// and the accelerator core, checks command parity, counts run cycles and runs a watchdog.
module job_control #(
    parameter int DONE_DELAY = 2,
    parameter int CNT_W      = 32,
    parameter int PARITY_EN  = 1,
    parameter int TIMEOUT    = 0
) (
    input logic         ha_pclock,
    input logic         reset,
    job_control_if.slave bus
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RESETTING = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    localparam logic [7:0] CMD_RESET = 8'h80;
    localparam logic [7:0] CMD_START = 8'h90;
    localparam logic [7:0] CMD_LLCMD = 8'h45;

    localparam logic [0:63] ERR_PARITY  = 64'h1;
    localparam logic [0:63] ERR_TIMEOUT = 64'h2;

    localparam logic [3:0]       DLY_LOAD = 4'(DONE_DELAY - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [3:0]       dly_cnt;
    logic             running_q;
    logic             jdone_q;
    logic             jcack_q;
    logic [0:63]      jerror_q;
    logic             core_start_q;
    logic             core_reset_q;
    logic [0:63]      job_ea_q;
    logic [CNT_W-1:0] run_cycles_q;

    logic par_err;
    logic is_reset;
    logic is_llcmd;
    logic start_go;
    logic wd_hit;

    // Odd parity: a correct word plus its parity bit always has an odd number of ones.
    assign par_err  = (PARITY_EN != 0) && bus.ha_jval &&
                      (!(^{bus.ha_jcom, bus.ha_jcompar}) || !(^{bus.ha_jea, bus.ha_jeapar}));
    assign is_reset = bus.ha_jval && (bus.ha_jcom == CMD_RESET) && !par_err;
    assign is_llcmd = bus.ha_jval && (bus.ha_jcom == CMD_LLCMD) && !par_err;
    assign start_go = bus.ha_jval && (bus.ha_jcom == CMD_START) && !par_err && (state == ST_IDLE);
    assign wd_hit   = (TIMEOUT != 0) && (state == ST_RUN) && (run_cycles_q == WD_LAST);

    always_ff @(posedge ha_pclock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            dly_cnt      <= '0;
            running_q    <= 1'b0;
            jdone_q      <= 1'b0;
            jcack_q      <= 1'b0;
            jerror_q     <= '0;
            core_start_q <= 1'b0;
            core_reset_q <= 1'b0;
            job_ea_q     <= '0;
        end else begin
            core_start_q <= 1'b0;
            core_reset_q <= 1'b0;
            jdone_q      <= 1'b0;
            jcack_q      <= 1'b0;
            if (par_err) begin
                jdone_q   <= 1'b1;
                jerror_q  <= ERR_PARITY;
                running_q <= 1'b0;
                state     <= ST_IDLE;
            end else if (is_reset) begin
                // A RESET while already resetting simply reloads the delay, so only one jdone results.
                core_reset_q <= 1'b1;
                running_q    <= 1'b0;
                jerror_q     <= '0;
                if (DONE_DELAY <= 1) begin
                    jdone_q <= 1'b1;
                    state   <= ST_IDLE;
                end else begin
                    dly_cnt <= DLY_LOAD;
                    state   <= ST_RESETTING;
                end
            end else begin
                if (is_llcmd) begin
                    jcack_q <= 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        if (start_go) begin
                            running_q    <= 1'b1;
                            core_start_q <= 1'b1;
                            job_ea_q     <= bus.ha_jea;
                            jerror_q     <= '0;
                            state        <= ST_RUN;
                        end
                    end
                    ST_RESETTING: begin
                        if (dly_cnt <= 4'd1) begin
                            jdone_q <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            dly_cnt <= dly_cnt - 4'd1;
                        end
                    end
                    ST_RUN: begin
                        if (bus.core_done) begin
                            jdone_q   <= 1'b1;
                            jerror_q  <= bus.core_error;
                            running_q <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (wd_hit) begin
                            jdone_q   <= 1'b1;
                            jerror_q  <= ERR_TIMEOUT;
                            running_q <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Counts every cycle spent in RUN, sticks at all ones, and keeps its value once the job ends.
    always_ff @(posedge ha_pclock or posedge reset) begin
        if (reset) begin
            run_cycles_q <= '0;
        end else if (start_go) begin
            run_cycles_q <= '0;
        end else if ((state == ST_RUN) && (run_cycles_q != {CNT_W{1'b1}})) begin
            run_cycles_q <= run_cycles_q + CNT_W'(1);
        end
    end

    assign bus.ah_jrunning = running_q;
    assign bus.ah_jdone    = jdone_q;
    assign bus.ah_jcack    = jcack_q;
    assign bus.ah_jerror   = jerror_q;
    assign bus.core_start  = core_start_q;
    assign bus.core_reset  = core_reset_q;
    assign bus.job_ea      = job_ea_q;
    assign bus.run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_job_control.sv
// Directed bench for job_control: expected jdone events go into a scoreboard queue as commands
// are issued and are matched (edge and error code) whenever the DUT pulses ah_jdone.
module tb_job_control;

    localparam int DD    = 2;
    localparam int TO    = 8;
    localparam int CNT_W = 32;

    typedef struct {
        int          done_edge;
        logic [63:0] err;
    } exp_t;

    logic ha_pclock = 1'b0;
    logic reset     = 1'b1;
    int   edge_count = 0;
    int   vectors    = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    job_control_if #(.CNT_W(CNT_W)) jif ();

    job_control #(
        .DONE_DELAY(DD),
        .CNT_W     (CNT_W),
        .PARITY_EN (1),
        .TIMEOUT   (TO)
    ) dut (
        .ha_pclock(ha_pclock),
        .reset    (reset),
        .bus      (jif.slave)
    );

    always #5 ha_pclock = ~ha_pclock;

    always @(posedge ha_pclock) edge_count <= edge_count + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ha_pclock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [63:0] ea, input logic bad_par,
                                 output int n);
        jif.ha_jval    = 1'b1;
        jif.ha_jcom    = cmd;
        jif.ha_jcompar = (~^cmd) ^ bad_par;
        jif.ha_jea     = ea;
        jif.ha_jeapar  = ~^ea;
        @(posedge ha_pclock);
        #1;
        n = edge_count;
        jif.ha_jval = 1'b0;
    endtask

    task automatic push_done(input int e, input logic [63:0] err);
        exp_t x;
        x.done_edge = e;
        x.err       = err;
        exp_q.push_back(x);
    endtask

    // Every jdone pulse must match the oldest outstanding expectation.
    always @(negedge ha_pclock) begin
        if (jif.ah_jdone !== 1'b0) begin
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("[TB] FAIL jdone_unexpected: observed pulse after edge %0d, expected none", edge_count);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("jdone_edge", 64'(edge_count), 64'(e.done_edge));
                checkOutput("jdone_err", jif.ah_jerror, e.err);
            end
        end
    end

    initial begin
        int n;
        int n2;
        jif.ha_jval    = 1'b0;
        jif.ha_jcom    = '0;
        jif.ha_jcompar = 1'b1;
        jif.ha_jea     = '0;
        jif.ha_jeapar  = 1'b1;
        jif.core_done  = 1'b0;
        jif.core_error = '0;

        tick(2);
        checkOutput("rst_running", 64'(jif.ah_jrunning), 64'd0);
        checkOutput("rst_jdone", 64'(jif.ah_jdone), 64'd0);
        checkOutput("rst_jcack", 64'(jif.ah_jcack), 64'd0);
        checkOutput("rst_jerror", jif.ah_jerror, 64'd0);
        checkOutput("rst_core_start", 64'(jif.core_start), 64'd0);
        checkOutput("rst_core_reset", 64'(jif.core_reset), 64'd0);
        checkOutput("rst_job_ea", jif.job_ea, 64'd0);
        checkOutput("rst_run_cycles", 64'(jif.run_cycles), 64'd0);
        reset = 1'b0;
        tick(2);

        $display("[TB] RESET command");
        applyStimulus(8'h80, 64'd0, 1'b0, n);
        push_done(n + DD - 1, 64'd0);
        checkOutput("reset_core_reset", 64'(jif.core_reset), 64'd1);
        checkOutput("reset_running", 64'(jif.ah_jrunning), 64'd0);
        checkOutput("reset_no_early_done", 64'(jif.ah_jdone), 64'd0);
        tick(1);
        checkOutput("reset_core_reset_pulse", 64'(jif.core_reset), 64'd0);
        checkOutput("reset_jdone", 64'(jif.ah_jdone), 64'd1);
        tick(1);
        checkOutput("reset_jdone_pulse", 64'(jif.ah_jdone), 64'd0);

        $display("[TB] unknown command ignored");
        applyStimulus(8'h12, 64'd0, 1'b0, n);
        checkOutput("unk_jcack", 64'(jif.ah_jcack), 64'd0);
        checkOutput("unk_core_start", 64'(jif.core_start), 64'd0);
        checkOutput("unk_running", 64'(jif.ah_jrunning), 64'd0);

        $display("[TB] START then core_done");
        applyStimulus(8'h90, 64'h1000, 1'b0, n);
        push_done(n + 5, 64'd0);
        checkOutput("start_running", 64'(jif.ah_jrunning), 64'd1);
        checkOutput("start_core_start", 64'(jif.core_start), 64'd1);
        checkOutput("start_job_ea", jif.job_ea, 64'h1000);
        checkOutput("start_run_cycles", 64'(jif.run_cycles), 64'd0);
        checkOutput("start_jerror", jif.ah_jerror, 64'd0);
        tick(1);
        checkOutput("start_core_start_pulse", 64'(jif.core_start), 64'd0);
        tick(3);
        checkOutput("start_running_n5", 64'(jif.ah_jrunning), 64'd1);
        jif.core_done  = 1'b1;
        jif.core_error = 64'd0;
        tick(1);
        jif.core_done = 1'b0;
        checkOutput("done_running", 64'(jif.ah_jrunning), 64'd0);
        checkOutput("done_run_cycles", 64'(jif.run_cycles), 64'd5);
        tick(2);
        checkOutput("done_run_cycles_hold", 64'(jif.run_cycles), 64'd5);

        $display("[TB] START with bad parity");
        applyStimulus(8'h90, 64'h2000, 1'b1, n);
        push_done(n, 64'd1);
        checkOutput("par_running", 64'(jif.ah_jrunning), 64'd0);
        checkOutput("par_core_start", 64'(jif.core_start), 64'd0);
        checkOutput("par_jerror", jif.ah_jerror, 64'd1);
        tick(2);

        $display("[TB] watchdog expiry");
        applyStimulus(8'h90, 64'h3000, 1'b0, n);
        push_done(n + TO, 64'd2);
        for (int i = 0; i < TO; i++) begin
            checkOutput("wd_running", 64'(jif.ah_jrunning), 64'd1);
            tick(1);
        end
        checkOutput("wd_running_off", 64'(jif.ah_jrunning), 64'd0);
        checkOutput("wd_jerror", jif.ah_jerror, 64'd2);
        checkOutput("wd_run_cycles", 64'(jif.run_cycles), 64'(TO));
        tick(2);

        $display("[TB] core_done on watchdog edge");
        applyStimulus(8'h90, 64'h4000, 1'b0, n);
        push_done(n + TO, 64'hDEAD_BEEF_0000_00A5);
        tick(TO - 1);
        jif.core_done  = 1'b1;
        jif.core_error = 64'hDEAD_BEEF_0000_00A5;
        tick(1);
        jif.core_done  = 1'b0;
        jif.core_error = '0;
        checkOutput("wdcd_jerror", jif.ah_jerror, 64'hDEAD_BEEF_0000_00A5);
        checkOutput("wdcd_running", 64'(jif.ah_jrunning), 64'd0);
        tick(2);

        $display("[TB] LLCMD, second START and RESET during RUN");
        applyStimulus(8'h90, 64'h5000, 1'b0, n);
        tick(1);
        applyStimulus(8'h45, 64'd0, 1'b0, n);
        checkOutput("llcmd_jcack", 64'(jif.ah_jcack), 64'd1);
        checkOutput("llcmd_running", 64'(jif.ah_jrunning), 64'd1);
        tick(1);
        checkOutput("llcmd_jcack_pulse", 64'(jif.ah_jcack), 64'd0);
        applyStimulus(8'h90, 64'h6000, 1'b0, n);
        checkOutput("restart_core_start", 64'(jif.core_start), 64'd0);
        checkOutput("restart_job_ea", jif.job_ea, 64'h5000);
        checkOutput("restart_running", 64'(jif.ah_jrunning), 64'd1);
        applyStimulus(8'h80, 64'd0, 1'b0, n);
        push_done(n + DD - 1, 64'd0);
        checkOutput("runreset_core_reset", 64'(jif.core_reset), 64'd1);
        checkOutput("runreset_running", 64'(jif.ah_jrunning), 64'd0);
        tick(3);

        $display("[TB] RESET while resetting");
        applyStimulus(8'h80, 64'd0, 1'b0, n);
        applyStimulus(8'h80, 64'd0, 1'b0, n2);
        push_done(n2 + DD - 1, 64'd0);
        checkOutput("rr_core_reset", 64'(jif.core_reset), 64'd1);
        tick(3);

        $display("[TB] async reset while resetting");
        applyStimulus(8'h80, 64'd0, 1'b0, n);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_core_reset", 64'(jif.core_reset), 64'd0);
        checkOutput("async_jdone", 64'(jif.ah_jdone), 64'd0);
        checkOutput("async_running", 64'(jif.ah_jrunning), 64'd0);
        checkOutput("async_job_ea", jif.job_ea, 64'd0);
        tick(2);
        reset = 1'b0;
        tick(4);

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/job_control.md
Name: job_control

Overview:
- Parametrised PSL job-control engine; replaces the hard-coded reset/start case logic and external jdone shift register in the AFU top.
- Decodes ha_jval/ha_jcom and drives ah_jrunning, ah_jdone, ah_jcack and ah_jerror.
- Hands start, reset and WED address to the accelerator core and collects its completion status.
- New relative to the previous generation: programmable done latency, LLCMD acknowledge, parity checking, run-cycle counter and watchdog timeout.

Parameters:
- DONE_DELAY, 2: cycles from the RESET command sample to the ah_jdone pulse; legal range 1..15.
- CNT_W, 32: width of the run-cycle counter.
- PARITY_EN, 1: 1 = check odd parity on ha_jcom and ha_jea; 0 = parity inputs ignored.
- TIMEOUT, 0: watchdog length in run cycles; 0 disables the watchdog. Must be < 2^CNT_W.

Ports:
- ha_pclock  in  1  clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ha_jval  in  1  job command valid.
- ha_jcom  in  [0:7]  job command.
- ha_jcompar  in  1  odd parity for ha_jcom.
- ha_jea  in  [0:63]  job effective address (WED).
- ha_jeapar  in  1  odd parity for ha_jea.
- core_done  in  1  core completion pulse.
- core_error  in  [0:63]  core status; sampled with core_done.
- ah_jrunning  out  1  job running.
- ah_jdone  out  1  one-cycle done pulse.
- ah_jcack  out  1  one-cycle LLCMD acknowledge.
- ah_jerror  out  [0:63]  completion error code.
- core_start  out  1  one-cycle start pulse to the core.
- core_reset  out  1  one-cycle reset pulse to the core.
- job_ea  out  [0:63]  captured WED address.
- run_cycles  out  [CNT_W-1:0]  cycles spent in RUN, saturating.

Behaviour:
- Reset values: all outputs 0; state IDLE. Outputs are registered.
- States: IDLE, RESETTING, RUN.
- Commands, sampled at edge N when ha_jval=1:
  - 0x80 RESET: valid in any state. core_reset=1 and ah_jrunning=0 at N+1. Enter RESETTING; ah_jdone=1 exactly at N+DONE_DELAY for one cycle with ah_jerror=0, then IDLE. A RESET received while already RESETTING restarts the delay count and produces only one jdone.
  - 0x90 START: accepted in IDLE only; ignored in RESETTING and RUN. At N+1: ah_jrunning=1, core_start=1, job_ea=ha_jea, run_cycles=0, ah_jerror=0; state RUN.
  - 0x45 LLCMD: any state; ah_jcack=1 at N+1 for one cycle. No state change.
  - Other codes: ignored, no outputs change.
- Parity: with PARITY_EN=1, an error is ^{ha_jcom,ha_jcompar}==0 or ^{ha_jea,ha_jeapar}==0. On error the command is discarded; ah_jdone=1 at N+1, ah_jerror=64'h1, ah_jrunning=0, state IDLE. This abort applies from any state and takes priority over all else.
- RUN completion: core_done sampled at edge M produces ah_jdone=1 at M+1 with ah_jerror=core_error and ah_jrunning=0; state IDLE. core_done outside RUN is ignored.
- run_cycles: increments every cycle in RUN, saturates at all ones, holds its value after leaving RUN.
- Watchdog: with TIMEOUT>0, if run_cycles==TIMEOUT-1 in RUN with no core_done, the next edge gives ah_jdone=1, ah_jerror=64'h2, ah_jrunning=0, state IDLE. A core_done in the same cycle wins; core_error is reported.
- Priority within one edge: parity error > RESET > core_done > watchdog.
- ah_jerror holds its last value until the next accepted START, RESET or error done.
- Asynchronous reset mid-job: immediate return to reset values; no jdone is emitted.

Test Plan:
- RESET (0x80) with DONE_DELAY=2, sampled at N: core_reset=1 at N+1, ah_jdone=1 only at N+2, ah_jerror=0.
- START (0x90) with ha_jea=64'h1000 at N, core_done with core_error=0 at N+5: ah_jrunning=1 over N+1..N+5, core_start=1 at N+1, job_ea=64'h1000, ah_jdone=1 and ah_jrunning=0 at N+6, run_cycles=5.
- START with ha_jcompar flipped (PARITY_EN=1): no start; ah_jdone=1 at N+1, ah_jerror=1, ah_jrunning stays 0.
- TIMEOUT=8, START at N with no core_done: ah_jrunning high N+1..N+8, ah_jdone=1 at N+9 with ah_jerror=2. Repeat with core_done at N+8: ah_jerror=core_error.
- LLCMD (0x45) during RUN: ah_jcack=1 for one cycle, ah_jrunning stays 1. Second START during RUN is ignored; RESET during RUN gives core_reset, ah_jrunning=0, and jdone after DONE_DELAY.
- Assert reset in RESETTING one cycle before jdone is due: all outputs 0 immediately, no jdone pulse afterwards.
